adsr_envelope_stepper: RTL and testbench
========================================

// Module: adsr_envelope_stepper
// PURPOSE
//  Consumer of the three pot-driven variable clocks (attack/decay/release rate clocks).
//  Synchronises each rate clock, converts its rising edges into single-cycle step
//  pulses, and steps an ADSR envelope level up/down per stage under control of a note gate.
//  Output envelope level feeds the amplitude multiplier ahead of the audio DAC path.
// PARAMETERS
//  ENV_W   8   envelope level width; full scale = 2**ENV_W-1
//  STEP    1   level increment/decrement per rate-clock edge (1..2**ENV_W-1)
// PORTS
//  clk            in   1      system clock; single clock domain for all state
//  rst_n          in   1      asynchronous, active-low reset
//  gate           in   1      note on (1) / off (0); asynchronous to clk
//  attack_clk     in   1      attack rate clock from variable clock generator; async
//  decay_clk      in   1      decay rate clock; async
//  release_clk    in   1      release rate clock; async
//  sustain_level  in   10     sustain pot value 0-1023; target = sustain_level[9:10-ENV_W]
//  env_level      out  ENV_W  current envelope level
//  stage          out  3      IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//  active         out  1      1 whenever stage != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): env_level=0, stage=IDLE, active=0, all sync/edge flops=0.
//  Input conditioning: gate and each rate clock pass 2-FF synchroniser + edge detect.
//   Step pulse = sync_q2 & ~prev; high for exactly one clk cycle per input rising edge.
//   Latency: state/level register updates on the 3rd clk edge after input rises.
//   gate_rise / gate_fall pulses derived from the same synchronised gate.
//  FSM (one transition max per cycle; priority listed top-down):
//   any state, gate_rise      -> ATTACK; env_level retained (retrigger, no click to 0).
//   ATTACK/DECAY/SUSTAIN, gate_fall -> RELEASE; env_level retained.
//   ATTACK: attack step -> env += STEP, saturate at full scale; on reaching full scale -> DECAY.
//   DECAY: decay step -> env -= STEP; if result <= target, env=target and -> SUSTAIN.
//     Target already >= env on entry (e.g. target=full scale) -> SUSTAIN next cycle, env=target.
//   SUSTAIN: env_level follows target every cycle (pot moves track live); no step pulses used.
//   RELEASE: release step -> env -= STEP, floor at 0; on reaching 0 -> IDLE.
//   IDLE: env_level held at 0; step pulses ignored.
//  Step pulses for stages other than the current one are ignored (not queued).
//  gate_rise and a step pulse in the same cycle: transition wins, step discarded.
//  Arithmetic: compute in ENV_W+1 bits; clamp before register; no wrap-around ever.
//  Rate clock stopped (pot at 0 / held high): level holds; FSM waits indefinitely.
//  Reset asserted mid-envelope: immediate clear to IDLE/0; no release tail.
// STRUCTURE
//  Shared package: stage encodings (ST_IDLE..ST_RELEASE), stage width constant.
//  Sub-module: edge_sync (2-FF synchroniser + rising/falling pulse), instanced 4x
//   (gate, attack_clk, decay_clk, release_clk). FSM + level datapath in this module.
// TESTING (ENV_W=8, STEP=16 unless noted; sustain_level=512 -> target 128)
//  1 Reset: rst_n=0 mid-ATTACK at env=96 -> env_level=0, stage=0, active=0 immediately.
//  2 Full ADSR: gate=1, 16 attack edges -> env 16..240 then 255 (clamp), stage=2;
//    8 decay edges -> 239..143 then 128, stage=3; gate=0 -> stage=4;
//    8 release edges -> 112..0, stage=0, active=0.
//  3 Latency: single attack_clk rise -> env_level changes on exactly the 3rd clk edge;
//    attack_clk held high 50 cycles -> exactly one step.
//  4 Sustain tracking: in SUSTAIN change sustain_level 512->768 -> env_level=192 within 1 cycle.
//  5 Retrigger: gate 1->0->1 during RELEASE at env=64 -> stage=1, env continues 80,96,...
//  6 Foreign steps: decay/release edges in ATTACK and all steps in IDLE -> env_level unchanged.

Source files
------------

// File: rtl/adsr_envelope_stepper_pkg.sv
// Shared stage encodings and widths for the ADSR envelope stepper.
package adsr_envelope_stepper_pkg;

  localparam int STAGE_W = 3;

  localparam logic [STAGE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STAGE_W-1:0] ST_ATTACK  = 3'd1;
  localparam logic [STAGE_W-1:0] ST_DECAY   = 3'd2;
  localparam logic [STAGE_W-1:0] ST_SUSTAIN = 3'd3;
  localparam logic [STAGE_W-1:0] ST_RELEASE = 3'd4;

endpackage

// File: rtl/adsr_envelope_stepper_edge_sync.sv
// Two-flop synchroniser for an asynchronous input, followed by a one-cycle
// rising/falling edge pulse generator in the clk domain.
module adsr_envelope_stepper_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_q1;
  logic r_q2;
  logic r_prev;

  // Synchronise the input and remember the previous synchronised value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1   <= 1'b0;
      r_q2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_q1   <= i_async;
      r_q2   <= r_q1;
      r_prev <= r_q2;
    end
  end

  assign o_rise = r_q2 & ~r_prev;
  assign o_fall = ~r_q2 & r_prev;

endmodule

// File: rtl/adsr_envelope_stepper.sv
// ADSR envelope stepper: turns synchronised rate-clock edges into level steps
// and sequences attack/decay/sustain/release under control of the note gate.
//
//  state      | meaning
//  -----------+---------------------------------------------------------
//  ST_IDLE    | no note; level held at 0, rate steps ignored
//  ST_ATTACK  | level climbs by STEP per attack edge up to full scale
//  ST_DECAY   | level falls by STEP per decay edge down to sustain target
//  ST_SUSTAIN | level tracks the sustain pot every cycle
//  ST_RELEASE | level falls by STEP per release edge down to 0
module adsr_envelope_stepper
  import adsr_envelope_stepper_pkg::*;
#(
  parameter int ENV_W = 8,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               gate,
  input  logic               attack_clk,
  input  logic               decay_clk,
  input  logic               release_clk,
  input  logic [9:0]         sustain_level,
  output logic [ENV_W-1:0]   env_level,
  output logic [STAGE_W-1:0] stage,
  output logic               active
);

  localparam logic [ENV_W:0] FULL_X = {1'b0, {ENV_W{1'b1}}};
  localparam logic [ENV_W:0] STEP_X = (ENV_W+1)'(STEP);

  logic               w_gate_rise;
  logic               w_gate_fall;
  logic               w_atk_step;
  logic               w_dec_step;
  logic               w_rel_step;
  logic               w_atk_unused;
  logic               w_dec_unused;
  logic               w_rel_unused;
  logic               w_unused_lsb;

  logic [ENV_W-1:0]   r_env;
  logic [STAGE_W-1:0] r_stage;
  logic [ENV_W-1:0]   w_env_nxt;
  logic [STAGE_W-1:0] w_stage_nxt;

  logic [ENV_W-1:0]   w_target;
  logic [ENV_W:0]     w_env_x;
  logic [ENV_W:0]     w_tgt_x;
  logic [ENV_W:0]     w_sum;
  logic [ENV_W:0]     w_diff;
  logic               w_dec_hit;

  adsr_envelope_stepper_edge_sync u_sync_gate (
    .clk(clk), .rst_n(rst_n), .i_async(gate),
    .o_rise(w_gate_rise), .o_fall(w_gate_fall)
  );
  adsr_envelope_stepper_edge_sync u_sync_atk (
    .clk(clk), .rst_n(rst_n), .i_async(attack_clk),
    .o_rise(w_atk_step), .o_fall(w_atk_unused)
  );
  adsr_envelope_stepper_edge_sync u_sync_dec (
    .clk(clk), .rst_n(rst_n), .i_async(decay_clk),
    .o_rise(w_dec_step), .o_fall(w_dec_unused)
  );
  adsr_envelope_stepper_edge_sync u_sync_rel (
    .clk(clk), .rst_n(rst_n), .i_async(release_clk),
    .o_rise(w_rel_step), .o_fall(w_rel_unused)
  );

  // Only the top ENV_W bits of the pot set the target; the rest are dropped.
  assign w_target     = sustain_level[9 -: ENV_W];
  assign w_unused_lsb = ^sustain_level;

  // One guard bit so an add past full scale or a subtract below 0 is visible.
  assign w_env_x   = {1'b0, r_env};
  assign w_tgt_x   = {1'b0, w_target};
  assign w_sum     = w_env_x + STEP_X;
  assign w_diff    = w_env_x - STEP_X;
  assign w_dec_hit = (w_env_x < STEP_X) || (w_diff <= w_tgt_x);

  // Next stage/level: gate events take priority over any step in the same cycle.
  always_comb begin
    w_stage_nxt = r_stage;
    w_env_nxt   = r_env;
    if (w_gate_rise) begin
      w_stage_nxt = ST_ATTACK;
    end else if (w_gate_fall &&
                 (r_stage == ST_ATTACK || r_stage == ST_DECAY || r_stage == ST_SUSTAIN)) begin
      w_stage_nxt = ST_RELEASE;
    end else begin
      case (r_stage)
        ST_ATTACK: begin
          if (w_atk_step) begin
            if (w_sum >= FULL_X) begin
              w_env_nxt   = FULL_X[ENV_W-1:0];
              w_stage_nxt = ST_DECAY;
            end else begin
              w_env_nxt = w_sum[ENV_W-1:0];
            end
          end
        end
        ST_DECAY: begin
          if (w_tgt_x >= w_env_x) begin
            w_env_nxt   = w_target;
            w_stage_nxt = ST_SUSTAIN;
          end else if (w_dec_step) begin
            if (w_dec_hit) begin
              w_env_nxt   = w_target;
              w_stage_nxt = ST_SUSTAIN;
            end else begin
              w_env_nxt = w_diff[ENV_W-1:0];
            end
          end
        end
        ST_SUSTAIN: begin
          w_env_nxt = w_target;
        end
        ST_RELEASE: begin
          // A release entered at level 0 has nothing left to do.
          if (r_env == '0) begin
            w_stage_nxt = ST_IDLE;
          end else if (w_rel_step) begin
            if (w_env_x <= STEP_X) begin
              w_env_nxt   = '0;
              w_stage_nxt = ST_IDLE;
            end else begin
              w_env_nxt = w_diff[ENV_W-1:0];
            end
          end
        end
        default: begin
          w_env_nxt   = '0;
          w_stage_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Stage and level registers; reset drops straight to idle with no tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= ST_IDLE;
      r_env   <= '0;
    end else begin
      r_stage <= w_stage_nxt;
      r_env   <= w_env_nxt;
    end
  end

  assign env_level = r_env;
  assign stage     = r_stage;
  assign active    = (r_stage != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope_stepper.sv
// Directed bench for adsr_envelope_stepper (ENV_W=8, STEP=16) with a
// cycle-level reference model compared on every falling clock edge.
module tb_adsr_envelope_stepper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       gate = 1'b0;
  logic       attack_clk = 1'b0;
  logic       decay_clk = 1'b0;
  logic       release_clk = 1'b0;
  logic [9:0] sustain_level = 10'd512;
  logic [7:0] env_level;
  logic [2:0] stage;
  logic       active;

  int checks = 0;
  int errors = 0;

  adsr_envelope_stepper #(.ENV_W(8), .STEP(16)) dut (
    .clk(clk), .rst_n(rst_n), .gate(gate),
    .attack_clk(attack_clk), .decay_clk(decay_clk), .release_clk(release_clk),
    .sustain_level(sustain_level),
    .env_level(env_level), .stage(stage), .active(active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: an input edge acts on the third clk edge after it is sampled.
  int       m_lvl = 0;
  int       m_stg = 0;
  bit [2:0] h_g = '0, h_a = '0, h_d = '0, h_r = '0;

  always @(posedge clk or negedge rst_n) begin
    bit gr, gf, ap, dp, rp;
    int tgt;
    if (!rst_n) begin
      m_lvl = 0; m_stg = 0;
      h_g = '0; h_a = '0; h_d = '0; h_r = '0;
    end else begin
      gr = h_g[1] & ~h_g[2];
      gf = ~h_g[1] & h_g[2];
      ap = h_a[1] & ~h_a[2];
      dp = h_d[1] & ~h_d[2];
      rp = h_r[1] & ~h_r[2];
      tgt = int'(sustain_level) / 4;
      if (gr) m_stg = 1;
      else if (gf && m_stg >= 1 && m_stg <= 3) m_stg = 4;
      else begin
        case (m_stg)
          1: if (ap) begin
               m_lvl = m_lvl + 16;
               if (m_lvl >= 255) begin m_lvl = 255; m_stg = 2; end
             end
          2: if (tgt >= m_lvl) begin m_lvl = tgt; m_stg = 3; end
             else if (dp) begin
               m_lvl = m_lvl - 16;
               if (m_lvl <= tgt) begin m_lvl = tgt; m_stg = 3; end
             end
          3: m_lvl = tgt;
          4: if (m_lvl == 0) m_stg = 0;
             else if (rp) begin
               m_lvl = m_lvl - 16;
               if (m_lvl <= 0) begin m_lvl = 0; m_stg = 0; end
             end
          default: m_lvl = 0;
        endcase
      end
      h_g = {h_g[1:0], gate};
      h_a = {h_a[1:0], attack_clk};
      h_d = {h_d[1:0], decay_clk};
      h_r = {h_r[1:0], release_clk};
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_env", int'(env_level), m_lvl);
    check("model_stage", int'(stage), m_stg);
    check("model_active", int'(active), int'(m_stg != 0));
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 attack, 1 decay, 2 release
  task automatic rate_edge(input int which);
    case (which)
      0: attack_clk = 1'b1;
      1: decay_clk = 1'b1;
      default: release_clk = 1'b1;
    endcase
    wait_cyc(4);
    attack_clk = 1'b0; decay_clk = 1'b0; release_clk = 1'b0;
    wait_cyc(4);
  endtask

  initial begin
    wait_cyc(3);
    check("reset_env", int'(env_level), 0);
    check("reset_stage", int'(stage), 0);
    check("reset_active", int'(active), 0);
    rst_n = 1'b1;
    wait_cyc(2);

    // Steps in IDLE are ignored.
    rate_edge(0); rate_edge(1); rate_edge(2);
    check("idle_steps_env", int'(env_level), 0);
    check("idle_steps_stage", int'(stage), 0);

    gate = 1'b1;
    wait_cyc(5);
    check("gate_on_stage", int'(stage), 1);
    check("gate_on_env", int'(env_level), 0);

    // Latency: a single rise lands on the third clk edge; holding high gives one step.
    attack_clk = 1'b1;
    @(posedge clk); #1 check("lat_edge1", int'(env_level), 0);
    @(posedge clk); #1 check("lat_edge2", int'(env_level), 0);
    @(posedge clk); #1 check("lat_edge3", int'(env_level), 16);
    wait_cyc(50);
    check("held_high_one_step", int'(env_level), 16);
    attack_clk = 1'b0;
    wait_cyc(4);

    // Foreign steps in ATTACK.
    rate_edge(1); rate_edge(2);
    check("foreign_attack_env", int'(env_level), 16);
    check("foreign_attack_stage", int'(stage), 1);

    for (int i = 0; i < 14; i++) rate_edge(0);
    check("attack_240", int'(env_level), 240);
    rate_edge(0);
    check("attack_clamp", int'(env_level), 255);
    check("to_decay", int'(stage), 2);

    for (int i = 0; i < 7; i++) rate_edge(1);
    check("decay_143", int'(env_level), 143);
    rate_edge(1);
    check("decay_target", int'(env_level), 128);
    check("to_sustain", int'(stage), 3);

    // Sustain follows the pot on the next clk edge.
    sustain_level = 10'd768;
    @(posedge clk); #1 check("sustain_track", int'(env_level), 192);
    wait_cyc(2);

    gate = 1'b0;
    wait_cyc(4);
    check("to_release", int'(stage), 4);
    check("release_start_env", int'(env_level), 192);
    for (int i = 0; i < 8; i++) rate_edge(2);
    check("release_64", int'(env_level), 64);

    // Retrigger from RELEASE keeps the level.
    gate = 1'b1;
    wait_cyc(4);
    check("retrig_stage", int'(stage), 1);
    check("retrig_env", int'(env_level), 64);
    rate_edge(0);
    check("retrig_80", int'(env_level), 80);
    rate_edge(0);
    check("retrig_96", int'(env_level), 96);

    // Reset mid-attack clears immediately.
    #2 rst_n = 1'b0;
    #1;
    check("midrst_env", int'(env_level), 0);
    check("midrst_stage", int'(stage), 0);
    check("midrst_active", int'(active), 0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(6);
    gate = 1'b0;
    wait_cyc(6);
    check("fall_at_zero_idle", int'(stage), 0);

    // Decay entered with target at full scale goes straight to SUSTAIN.
    gate = 1'b1;
    wait_cyc(5);
    for (int i = 0; i < 15; i++) rate_edge(0);
    sustain_level = 10'd1023;
    rate_edge(0);
    check("full_target_stage", int'(stage), 3);
    check("full_target_env", int'(env_level), 255);

    // Full release to floor.
    gate = 1'b0;
    wait_cyc(4);
    for (int i = 0; i < 15; i++) rate_edge(2);
    check("release_15", int'(env_level), 15);
    rate_edge(2);
    check("release_floor", int'(env_level), 0);
    check("release_idle", int'(stage), 0);
    check("release_inactive", int'(active), 0);

    wait_cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
